full_adder_using_half_adder: RTL and testbench

FULL_ADDER_USING_HALF_ADDER -- requirements
Module: full_adder_using_half_adder

---
 rtl/full_adder_pkg.sv | 7 +
 rtl/half_adder.sv | 15 +
 rtl/full_adder_using_half_adder.sv | 72 +++++++
 tb/tb_full_adder_using_half_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared width constants for the ripple-carry adder built from half-adder cells.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 32'd1;
    localparam int FA_MAX_WIDTH     = 32'd64;

endpackage : full_adder_pkg

// File: rtl/half_adder.sv
// Single-bit half adder: purely combinational, no clock.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    // sum and carry of two single bits
    always_comb begin
        sum   = a ^ b;
        carry = a & b;
    end

endmodule : half_adder

// File: rtl/full_adder_using_half_adder.sv
// WIDTH-bit ripple-carry adder; each bit is a full-adder cell of two half adders,
// with {carry_out, sum_out} registered one clock after the inputs are sampled.
module full_adder_using_half_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    logic [WIDTH:0]   ripple_s;
    logic [WIDTH-1:0] ha1_sum_s;
    logic [WIDTH-1:0] ha1_carry_s;
    logic [WIDTH-1:0] ha2_sum_s;
    logic [WIDTH-1:0] ha2_carry_s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;

    assign ripple_s[0] = c_in;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            half_adder u_ha_ab (
                .a     (a_in[i]),
                .b     (b_in[i]),
                .sum   (ha1_sum_s[i]),
                .carry (ha1_carry_s[i])
            );

            half_adder u_ha_cin (
                .a     (ha1_sum_s[i]),
                .b     (ripple_s[i]),
                .sum   (ha2_sum_s[i]),
                .carry (ha2_carry_s[i])
            );

            // the two half-adder carries can never both be set, so OR is exact
            assign ripple_s[i+1] = ha1_carry_s[i] | ha2_carry_s[i];
        end
    endgenerate

    // next-state values for the output register
    always_comb begin
        sum_d   = ha2_sum_s;
        carry_d = ripple_s[WIDTH];
    end

    // output register; reset clears it asynchronously and drops any pending result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum_out   = sum_q;
    assign carry_out = carry_q;

endmodule : full_adder_using_half_adder

// File: tb/tb_full_adder_using_half_adder.sv
// Directed bench for the half-adder based full adder: a WIDTH=1 and a WIDTH=8 instance.
module tb_full_adder_using_half_adder;

    logic       clk;
    logic       rst;
    logic       a1, b1, c1;
    logic       s1, co1;
    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] s8;
    logic       co8;

    int n_vec;
    int n_err;

    // REQ-014 truth table, indexed by {a,b,c}
    logic [7:0] tt_sum;
    logic [7:0] tt_carry;

    full_adder_using_half_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a1),
        .b_in      (b1),
        .c_in      (c1),
        .sum_out   (s1),
        .carry_out (co1)
    );

    full_adder_using_half_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a8),
        .b_in      (b8),
        .c_in      (c8),
        .sum_out   (s8),
        .carry_out (co8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        #1;
        n_vec++;
        if ({co1, s1} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_before_edge: got c=%b s=%b, want c=0 s=0", co1, s1);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({co1, s1} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_after_edge: got c=%b s=%b, want c=0 s=0", co1, s1);
        end
        n_vec++;
        if ({co8, s8} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_w8: got c=%b s=%h, want c=0 s=00", co8, s8);
        end
        rst = 1'b0;
    endtask

    task automatic test_exhaustive();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {a1, b1, c1} = v;
            @(posedge clk);
            #1;
            n_vec++;
            if (s1 !== tt_sum[v] || co1 !== tt_carry[v]) begin
                n_err++;
                $display("FAIL exhaustive abc=%b: got s=%b c=%b, want s=%b c=%b",
                         v, s1, co1, tt_sum[v], tt_carry[v]);
            end
        end
    endtask

    task automatic test_toggle();
        logic [2:0] v;
        for (int cyc = 0; cyc < 60; cyc++) begin
            v = {cyc[0], ((cyc / 2) % 2) == 1, ((cyc / 3) % 2) == 1};
            {a1, b1, c1} = v;
            @(posedge clk);
            #1;
            n_vec++;
            if (s1 !== tt_sum[v] || co1 !== tt_carry[v]) begin
                n_err++;
                $display("FAIL toggle cyc=%0d abc=%b: got s=%b c=%b, want s=%b c=%b",
                         cyc, v, s1, co1, tt_sum[v], tt_carry[v]);
            end
        end
    endtask

    task automatic test_hold_between_edges();
        {a1, b1, c1} = 3'b100;
        @(posedge clk);
        #1;
        {a1, b1, c1} = 3'b111;
        #2;
        n_vec++;
        if ({co1, s1} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_between_edges: got c=%b s=%b, want c=0 s=1", co1, s1);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({co1, s1} !== 2'b11) begin
            n_err++;
            $display("FAIL hold_next_edge: got c=%b s=%b, want c=1 s=1", co1, s1);
        end
    endtask

    task automatic test_width8();
        logic [7:0] va [6];
        logic [7:0] vb [6];
        logic       vc [6];
        logic [7:0] es [6];
        logic       ec [6];
        va = '{8'hFF, 8'hFF, 8'h0F, 8'h80, 8'hA5, 8'h00};
        vb = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'h00};
        vc = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        es = '{8'h00, 8'hFF, 8'h10, 8'h00, 8'hFF, 8'h00};
        ec = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
        for (int k = 0; k < 6; k++) begin
            a8 = va[k]; b8 = vb[k]; c8 = vc[k];
            @(posedge clk);
            #1;
            n_vec++;
            if (s8 !== es[k] || co8 !== ec[k]) begin
                n_err++;
                $display("FAIL width8 %h+%h+%b: got s=%h c=%b, want s=%h c=%b",
                         va[k], vb[k], vc[k], s8, co8, es[k], ec[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        {a1, b1, c1} = 3'b100;
        @(posedge clk);
        #1;
        n_vec++;
        if (s1 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_precond: got s=%b, want s=1", s1);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({co1, s1} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_reset_clear: got c=%b s=%b, want c=0 s=0", co1, s1);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({co1, s1} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_reset_held: got c=%b s=%b, want c=0 s=0", co1, s1);
        end
    endtask

    task automatic test_release();
        {a1, b1, c1} = 3'b100;
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({co1, s1} !== 2'b00) begin
            n_err++;
            $display("FAIL release_before_edge: got c=%b s=%b, want c=0 s=0", co1, s1);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({co1, s1} !== 2'b01) begin
            n_err++;
            $display("FAIL release_first_edge: got c=%b s=%b, want c=0 s=1", co1, s1);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        tt_sum   = 8'b1001_0110;
        tt_carry = 8'b1110_1000;
        rst      = 1'b1;
        test_reset();
        test_exhaustive();
        test_toggle();
        test_hold_between_edges();
        test_width8();
        test_mid_reset();
        test_release();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_full_adder_using_half_adder
